// File: rtl/my_sys_mem_test_pkg.sv
// Shared definitions for the my_sys on-chip RAM self-test master:
// FSM state encoding, the test pattern generator and common constants.
package my_sys_mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR0   = 3'd1,
    ST_RD0   = 3'd2,
    ST_WR1   = 3'd3,
    ST_RD1   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic [15:0] DEF_SEED    = 16'hA5C3;
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Wide working width for the pattern; callers cast down to their data width.
  localparam int PAT_W = 64;

  // Pattern for one word: seed XOR address, bitwise inverted for the second round.
  function automatic logic [PAT_W-1:0] pattern_word(
    input logic [PAT_W-1:0] seed,
    input logic [PAT_W-1:0] addr,
    input logic             invert
  );
    logic [PAT_W-1:0] p;
    p = seed ^ addr;
    if (invert) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/my_sys_rd_compare_pipe.sv
// Read-compare pipe: carries (address, expected) for each issued read through
// READ_LATENCY stages so it meets its readdata, then counts mismatches
// (saturating) and captures the address of the first one.
module my_sys_rd_compare_pipe
  import my_sys_mem_test_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_exp,
  input  logic [DATA_W-1:0] readdata,
  output logic              pending,
  output logic [15:0]       err_cnt_nxt,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic              vld_r   [1:READ_LATENCY];
  logic [ADDR_W-1:0] addr_p_r [1:READ_LATENCY];
  logic [DATA_W-1:0] exp_p_r  [1:READ_LATENCY];
  logic [15:0]       cnt_r;
  logic [ADDR_W-1:0] first_r;
  logic [ADDR_W-1:0] first_nxt_s;
  logic              pending_s;

  // Shift the valid/addr/expected pipe and register the error results.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= READ_LATENCY; i++) begin
        vld_r[i]    <= 1'b0;
        addr_p_r[i] <= {ADDR_W{1'b0}};
        exp_p_r[i]  <= {DATA_W{1'b0}};
      end
      cnt_r   <= 16'd0;
      first_r <= {ADDR_W{1'b0}};
    end else begin
      for (int i = READ_LATENCY; i >= 2; i--) begin
        vld_r[i]    <= vld_r[i-1];
        addr_p_r[i] <= addr_p_r[i-1];
        exp_p_r[i]  <= exp_p_r[i-1];
      end
      vld_r[1]    <= push;
      addr_p_r[1] <= push_addr;
      exp_p_r[1]  <= push_exp;
      cnt_r       <= err_cnt_nxt;
      first_r     <= first_nxt_s;
    end
  end

  // Compare the pipe tail against readdata and form the next error state.
  always_comb begin
    err_cnt_nxt = cnt_r;
    first_nxt_s = first_r;
    pending_s   = 1'b0;
    // Beats that will still be in flight after this edge (tail is consumed now).
    for (int i = 1; i < READ_LATENCY; i++) begin
      pending_s = pending_s | vld_r[i];
    end
    if (clr) begin
      err_cnt_nxt = 16'd0;
      first_nxt_s = {ADDR_W{1'b0}};
    end else if (vld_r[READ_LATENCY] && (readdata != exp_p_r[READ_LATENCY])) begin
      if (cnt_r != ERR_CNT_MAX) begin
        err_cnt_nxt = cnt_r + 16'd1;
      end else begin
        err_cnt_nxt = cnt_r;
      end
      // A zero count means no earlier mismatch (the counter never wraps).
      if (cnt_r == 16'd0) begin
        first_nxt_s = addr_p_r[READ_LATENCY];
      end else begin
        first_nxt_s = first_r;
      end
    end else begin
      err_cnt_nxt = cnt_r;
    end
  end

  assign pending        = pending_s;
  assign error_count    = cnt_r;
  assign first_err_addr = first_r;

endmodule

// File: rtl/my_sys_mem_test_master.sv
// Avalon-MM self-test host for the my_sys on-chip RAM: writes a pattern over
// a word range, reads it back, repeats with the inverted pattern, and reports
// pass/fail, error count and first failing address. All bus outputs are
// registered so a command appears the cycle after the FSM decides on it.
module my_sys_mem_test_master
  import my_sys_mem_test_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 16,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] SEED         = DEF_SEED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     address,
  output logic                  chipselect,
  output logic                  clken,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int                BE_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   base_r, base_nxt_s;
  logic [ADDR_W-1:0]   last_r, last_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic                cs_r, cs_nxt_s;
  logic                wr_r, wr_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic [BE_W-1:0]     be_r, be_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic                pass_r, pass_nxt_s;
  logic                clr_s;
  logic                at_last_s;
  logic                push_s;
  logic [DATA_W-1:0]   push_exp_s;
  logic                pending_s;
  logic [15:0]         err_cnt_nxt_s;

  function automatic logic [DATA_W-1:0] pat_at(input logic [ADDR_W-1:0] a, input logic inv);
    return DATA_W'(pattern_word(PAT_W'(SEED), PAT_W'(a), inv));
  endfunction

  // Every read beat on the bus enters the compare pipe with its expected word.
  assign push_s     = (state_r == ST_RD0) || (state_r == ST_RD1);
  assign push_exp_s = pat_at(addr_r, state_r == ST_RD1);

  my_sys_rd_compare_pipe #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clr            (clr_s),
    .push           (push_s),
    .push_addr      (addr_r),
    .push_exp       (push_exp_s),
    .readdata       (readdata),
    .pending        (pending_s),
    .err_cnt_nxt    (err_cnt_nxt_s),
    .error_count    (error_count),
    .first_err_addr (first_err_addr)
  );

  // State and registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      base_r  <= {ADDR_W{1'b0}};
      last_r  <= {ADDR_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      cs_r    <= 1'b0;
      wr_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      base_r  <= base_nxt_s;
      last_r  <= last_nxt_s;
      addr_r  <= addr_nxt_s;
      cs_r    <= cs_nxt_s;
      wr_r    <= wr_nxt_s;
      wdata_r <= wdata_nxt_s;
      be_r    <= be_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      pass_r  <= pass_nxt_s;
    end
  end

  // Next-state and next-output decode of the test sequencer.
  always_comb begin
    state_nxt_s = state_r;
    base_nxt_s  = base_r;
    last_nxt_s  = last_r;
    addr_nxt_s  = addr_r;
    cs_nxt_s    = cs_r;
    wr_nxt_s    = wr_r;
    wdata_nxt_s = wdata_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = done_r;
    pass_nxt_s  = pass_r;
    clr_s       = 1'b0;
    at_last_s   = (addr_r == last_r);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_WR0;
          base_nxt_s  = base_addr;
          last_nxt_s  = last_addr;
          addr_nxt_s  = base_addr;
          cs_nxt_s    = 1'b1;
          wr_nxt_s    = 1'b1;
          wdata_nxt_s = pat_at(base_addr, 1'b0);
          busy_nxt_s  = 1'b1;
          done_nxt_s  = 1'b0;
          pass_nxt_s  = 1'b0;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_WR0, ST_WR1: begin
        if (at_last_s) begin
          state_nxt_s = (state_r == ST_WR0) ? ST_RD0 : ST_RD1;
          addr_nxt_s  = base_r;
          wr_nxt_s    = 1'b0;
          wdata_nxt_s = {DATA_W{1'b0}};
        end else begin
          addr_nxt_s  = addr_r + ADDR_ONE;
          wdata_nxt_s = pat_at(addr_r + ADDR_ONE, state_r == ST_WR1);
        end
      end
      ST_RD0: begin
        if (at_last_s) begin
          state_nxt_s = ST_WR1;
          addr_nxt_s  = base_r;
          wr_nxt_s    = 1'b1;
          wdata_nxt_s = pat_at(base_r, 1'b1);
        end else begin
          addr_nxt_s  = addr_r + ADDR_ONE;
        end
      end
      ST_RD1: begin
        if (at_last_s) begin
          state_nxt_s = ST_DRAIN;
          addr_nxt_s  = {ADDR_W{1'b0}};
          cs_nxt_s    = 1'b0;
        end else begin
          addr_nxt_s  = addr_r + ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        // Leave once the last in-flight beat is being compared this edge.
        if (!pending_s) begin
          state_nxt_s = ST_DONE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          pass_nxt_s  = (err_cnt_nxt_s == 16'd0);
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        addr_nxt_s  = {ADDR_W{1'b0}};
        cs_nxt_s    = 1'b0;
        wr_nxt_s    = 1'b0;
        wdata_nxt_s = {DATA_W{1'b0}};
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        pass_nxt_s  = 1'b0;
      end
    endcase
    be_nxt_s = cs_nxt_s ? {BE_W{1'b1}} : {BE_W{1'b0}};
  end

  assign address    = addr_r;
  assign chipselect = cs_r;
  assign clken      = busy_r;
  assign write      = wr_r;
  assign writedata  = wdata_r;
  assign byteenable = be_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;

endmodule

// File: tb/tb_my_sys_mem_test_master.sv
// Bench for my_sys_mem_test_master: instance A (READ_LATENCY=1) and instance B
// (READ_LATENCY=3), each with its own RAM model. Expected bus beats and final
// results are queued when a test is launched and checked as the DUT produces them.
module tb_my_sys_mem_test_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [9:0] base_addr;
  logic [9:0] last_addr;
  bit         sel;       // 0 -> instance A, 1 -> instance B
  bit         stuck_a;   // force readdata bit 0 low on instance A
  bit         mon_en;

  int checks = 0;
  int failures = 0;

  // Instance A signals
  logic        busy_a, done_a, pass_a, cs_a, clken_a, wr_a;
  logic [15:0] errs_a, wdata_a, rdata_a, rd_a;
  logic [9:0]  first_a, addr_a;
  logic [1:0]  be_a;
  // Instance B signals
  logic        busy_b, done_b, pass_b, cs_b, clken_b, wr_b;
  logic [15:0] errs_b, wdata_b, rdata_b;
  logic [9:0]  first_b, addr_b;
  logic [1:0]  be_b;

  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:1023];
  logic [15:0] rdp_b [0:2];

  my_sys_mem_test_master #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .base_addr(base_addr), .last_addr(last_addr),
    .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(errs_a), .first_err_addr(first_a),
    .address(addr_a), .chipselect(cs_a), .clken(clken_a), .write(wr_a), .writedata(wdata_a),
    .byteenable(be_a), .readdata(rdata_a)
  );

  my_sys_mem_test_master #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .base_addr(base_addr), .last_addr(last_addr),
    .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(errs_b), .first_err_addr(first_b),
    .address(addr_b), .chipselect(cs_b), .clken(clken_b), .write(wr_b), .writedata(wdata_b),
    .byteenable(be_b), .readdata(rdata_b)
  );

  // RAM model A: one-cycle read latency, optional stuck-at-0 on bit 0.
  always @(posedge clk) begin
    if (cs_a && clken_a) begin
      if (wr_a) mem_a[addr_a] <= wdata_a;
      else      rd_a <= mem_a[addr_a];
    end
  end
  assign rdata_a = stuck_a ? (rd_a & 16'hFFFE) : rd_a;

  // RAM model B: three-cycle read latency.
  always @(posedge clk) begin
    if (cs_b && clken_b) begin
      if (wr_b) mem_b[addr_b] <= wdata_b;
      else      rdp_b[0] <= mem_b[addr_b];
    end
    rdp_b[1] <= rdp_b[0];
    rdp_b[2] <= rdp_b[1];
  end
  assign rdata_b = rdp_b[2];

  // Views of the selected instance
  logic        v_busy, v_done, v_pass, v_cs, v_clken, v_wr;
  logic [15:0] v_errs, v_wdata;
  logic [9:0]  v_first, v_addr;
  logic [1:0]  v_be;
  assign v_busy  = sel ? busy_b  : busy_a;
  assign v_done  = sel ? done_b  : done_a;
  assign v_pass  = sel ? pass_b  : pass_a;
  assign v_cs    = sel ? cs_b    : cs_a;
  assign v_clken = sel ? clken_b : clken_a;
  assign v_wr    = sel ? wr_b    : wr_a;
  assign v_errs  = sel ? errs_b  : errs_a;
  assign v_wdata = sel ? wdata_b : wdata_a;
  assign v_first = sel ? first_b : first_a;
  assign v_addr  = sel ? addr_b  : addr_a;
  assign v_be    = sel ? be_b    : be_a;

  typedef struct {
    logic [9:0]  a;
    logic        w;
    logic [15:0] d;
  } beat_t;
  beat_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [9:0] a, input bit inv);
    logic [15:0] p;
    p = 16'hA5C3 ^ {6'd0, a};
    return inv ? ~p : p;
  endfunction

  // Bus monitor: every chipselect beat must match the next queued beat.
  always @(negedge clk) begin
    if (mon_en && v_cs) begin
      beat_t e;
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 32'(v_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("beat_addr", 32'(v_addr), 32'(e.a));
        check_val("beat_write", 32'(v_wr), 32'(e.w));
        if (e.w) check_val("beat_wdata", 32'(v_wdata), 32'(e.d));
        check_val("beat_be", 32'(v_be), 32'h3);
        check_val("beat_clken", 32'(v_clken), 32'h1);
      end
    end
  end

  task automatic check_idle(input string tag);
    check_val({tag, "_cs"}, 32'(v_cs), 32'h0);
    check_val({tag, "_wr"}, 32'(v_wr), 32'h0);
    check_val({tag, "_addr"}, 32'(v_addr), 32'h0);
    check_val({tag, "_wdata"}, 32'(v_wdata), 32'h0);
    check_val({tag, "_be"}, 32'(v_be), 32'h0);
    check_val({tag, "_clken"}, 32'(v_clken), 32'h0);
    check_val({tag, "_busy"}, 32'(v_busy), 32'h0);
    check_val({tag, "_done"}, 32'(v_done), 32'h0);
    check_val({tag, "_pass"}, 32'(v_pass), 32'h0);
    check_val({tag, "_errs"}, 32'(v_errs), 32'h0);
    check_val({tag, "_first"}, 32'(v_first), 32'h0);
  endtask

  // Queue the expected beats and results, launch, and check at done.
  task automatic run_test(input string tag, input bit s, input logic [9:0] b, input logic [9:0] l,
                          input bit stk, input bit spam);
    logic [9:0]  diff, a;
    logic [15:0] d;
    int n, exp_errs, exp_cyc, cyc;
    logic [9:0] exp_first;
    bit have_first, seen;
    sel = s;
    stuck_a = stk;
    diff = l - b;
    n = int'(diff) + 1;
    exp_errs = 0;
    exp_first = 10'd0;
    have_first = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < n; i++) begin
        a = b + 10'(i);
        exp_q.push_back('{a: a, w: 1'b1, d: pat(a, r != 0)});
      end
      for (int i = 0; i < n; i++) begin
        a = b + 10'(i);
        d = pat(a, r != 0);
        exp_q.push_back('{a: a, w: 1'b0, d: 16'h0});
        if (stk && d[0]) begin
          exp_errs++;
          if (!have_first) begin
            exp_first = a;
            have_first = 1'b1;
          end
        end
      end
    end
    exp_cyc = 4 * n + (s ? 3 : 1) + 1;

    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    last_addr = l;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check_val({tag, "_busy_after_start"}, 32'(v_busy), 32'h1);
        check_val({tag, "_errs_cleared"}, 32'(v_errs), 32'h0);
        check_val({tag, "_done_cleared"}, 32'(v_done), 32'h0);
        if (!spam) start = 1'b0;
      end
      if (v_done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      check_val({tag, "_done_timeout"}, 32'h0, 32'h1);
    end else begin
      check_val({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check_val({tag, "_pass"}, 32'(v_pass), 32'(exp_errs == 0));
      check_val({tag, "_errs"}, 32'(v_errs), 32'(exp_errs));
      check_val({tag, "_first"}, 32'(v_first), 32'(exp_first));
      check_val({tag, "_busy_end"}, 32'(v_busy), 32'h0);
      check_val({tag, "_clken_end"}, 32'(v_clken), 32'h0);
      check_val({tag, "_beats_left"}, 32'(exp_q.size()), 32'h0);
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = 10'd0;
    last_addr = 10'd0;
    sel = 1'b0;
    stuck_a = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst_a");
    sel = 1'b1;
    #1;
    check_idle("rst_b");
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_test("basic", 1'b0, 10'd0, 10'd3, 1'b0, 1'b0);
    run_test("stuck", 1'b0, 10'd0, 10'd3, 1'b1, 1'b0);
    run_test("wrap", 1'b0, 10'h3FE, 10'h001, 1'b0, 1'b0);
    run_test("spam", 1'b0, 10'd0, 10'd3, 1'b0, 1'b1);
    run_test("single", 1'b0, 10'd7, 10'd7, 1'b0, 1'b0);

    // Reset in the third cycle of RD0 (bus cycles 1-4 write, 5-7 read).
    mon_en = 1'b0;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    base_addr = 10'd0;
    last_addr = 10'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("mid_rd0_read", 32'({v_cs, v_wr}), 32'h2);
    check_val("mid_rd0_addr", 32'(v_addr), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_cs", 32'(v_cs), 32'h0);
    check_val("abort_busy", 32'(v_busy), 32'h0);
    check_val("abort_done", 32'(v_done), 32'h0);
    check_val("abort_errs", 32'(v_errs), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_quiet_cs", 32'(v_cs), 32'h0);
    check_val("abort_quiet_done", 32'(v_done), 32'h0);
    exp_q.delete();
    mon_en = 1'b1;
    run_test("after_abort", 1'b0, 10'd0, 10'd3, 1'b0, 1'b0);

    run_test("full", 1'b0, 10'h200, 10'h1FF, 1'b0, 1'b0);
    run_test("lat3", 1'b1, 10'd5, 10'd5, 1'b0, 1'b0);
    run_test("lat3_multi", 1'b1, 10'd100, 10'd107, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
